// File: rtl/operand_fetch_pkg.sv
// operand_fetch_pkg: shared types and sizing for the operand-fetch stage.
//   XLEN / NUM_REGS / REG_ADDR_W : data width, register count, index width
//   t_data, t_reg_addr           : data word and register index types
//   REG_ZERO                     : index of the hardwired-zero register
//   t_alu_operation              : ALU operation code issued downstream
package operand_fetch_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned NUM_REGS   = 32;
   localparam int unsigned REG_ADDR_W = $clog2(NUM_REGS);

   typedef logic [XLEN-1:0]       t_data;
   typedef logic [REG_ADDR_W-1:0] t_reg_addr;

   localparam t_reg_addr REG_ZERO = '0;

   typedef enum logic [3:0] {
      ALU_OP_ADD  = 4'd0,
      ALU_OP_SUB  = 4'd1,
      ALU_OP_AND  = 4'd2,
      ALU_OP_OR   = 4'd3,
      ALU_OP_XOR  = 4'd4,
      ALU_OP_SLL  = 4'd5,
      ALU_OP_SRL  = 4'd6,
      ALU_OP_SRA  = 4'd7,
      ALU_OP_SLT  = 4'd8,
      ALU_OP_SLTU = 4'd9
   } t_alu_operation;

endpackage

// File: rtl/operand_fetch_register_file.sv
// register_file: architectural register file, x0 hardwired to zero.
//   i_clk, i_rst          : clock, asynchronous active-high clear
//   i_rs1_addr/o_rs1_data : combinational read port 1 (write-first bypass)
//   i_rs2_addr/o_rs2_data : combinational read port 2 (write-first bypass)
//   i_wb_en/addr/data     : synchronous write port, writes to x0 dropped
module register_file
   import operand_fetch_pkg::*;
(
   input  logic      i_clk,
   input  logic      i_rst,
   input  t_reg_addr i_rs1_addr,
   output t_data     o_rs1_data,
   input  t_reg_addr i_rs2_addr,
   output t_data     o_rs2_data,
   input  logic      i_wb_en,
   input  t_reg_addr i_wb_addr,
   input  t_data     i_wb_data
);

   logic [NUM_REGS-1:0][XLEN-1:0] regs;
   logic                          wb_live;

   // Entry 0 is never written, so it stays at its cleared value of zero.
   assign wb_live = i_wb_en && (i_wb_addr != REG_ZERO);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         regs <= '0;
      end else if (wb_live) begin
         regs[i_wb_addr] <= i_wb_data;
      end
   end

   // A write landing this cycle is visible to reads in the same cycle.
   always_comb begin
      o_rs1_data = regs[i_rs1_addr];
      if (i_rs1_addr == REG_ZERO) begin
         o_rs1_data = '0;
      end else if (wb_live && (i_wb_addr == i_rs1_addr)) begin
         o_rs1_data = i_wb_data;
      end
   end

   always_comb begin
      o_rs2_data = regs[i_rs2_addr];
      if (i_rs2_addr == REG_ZERO) begin
         o_rs2_data = '0;
      end else if (wb_live && (i_wb_addr == i_rs2_addr)) begin
         o_rs2_data = i_wb_data;
      end
   end

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: register-read stage feeding the ALU.
//   i_clk, i_rst                 : clock, asynchronous active-high reset
//   i_valid/o_ready              : upstream handshake for decoded instructions
//   i_operation, i_rs1, i_rs2,
//   i_rd, i_imm, i_use_imm       : decoded instruction fields
//   i_flush                      : kill held and incoming instruction
//   i_wb_en/addr/data            : register file write port
//   o_valid/i_ready              : downstream handshake
//   o_operation, o_operand1,
//   o_operand2, o_rd             : registered instruction to execute
module operand_fetch
   import operand_fetch_pkg::*;
(
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_valid,
   output logic           o_ready,
   input  t_alu_operation i_operation,
   input  t_reg_addr      i_rs1,
   input  t_reg_addr      i_rs2,
   input  t_reg_addr      i_rd,
   input  t_data          i_imm,
   input  logic           i_use_imm,
   input  logic           i_flush,
   input  logic           i_wb_en,
   input  t_reg_addr      i_wb_addr,
   input  t_data          i_wb_data,
   output logic           o_valid,
   input  logic           i_ready,
   output t_alu_operation o_operation,
   output t_data          o_operand1,
   output t_data          o_operand2,
   output t_reg_addr      o_rd
);

   t_data     rs1_data;
   t_data     rs2_data;
   t_reg_addr held_rs1;
   t_reg_addr held_rs2;
   logic      held_use_imm;
   logic      accept;
   logic      stall;

   register_file u_register_file (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_rs1_addr (i_rs1),
      .o_rs1_data (rs1_data),
      .i_rs2_addr (i_rs2),
      .o_rs2_data (rs2_data),
      .i_wb_en    (i_wb_en),
      .i_wb_addr  (i_wb_addr),
      .i_wb_data  (i_wb_data)
   );

   assign o_ready = !o_valid || i_ready;
   assign accept  = i_valid && o_ready && !i_flush;
   assign stall   = o_valid && !i_ready;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_valid      <= 1'b0;
         o_operation  <= ALU_OP_ADD;
         o_operand1   <= '0;
         o_operand2   <= '0;
         o_rd         <= '0;
         held_rs1     <= '0;
         held_rs2     <= '0;
         held_use_imm <= 1'b0;
      end else if (i_flush) begin
         o_valid <= 1'b0;
      end else if (accept) begin
         o_valid      <= 1'b1;
         o_operation  <= i_operation;
         o_rd         <= i_rd;
         o_operand1   <= rs1_data;
         o_operand2   <= i_use_imm ? i_imm : rs2_data;
         held_rs1     <= i_rs1;
         held_rs2     <= i_rs2;
         held_use_imm <= i_use_imm;
      end else if (stall) begin
         // A stalled instruction snoops writeback so it never issues a
         // value that was overwritten after it was read.
         if (i_wb_en && (i_wb_addr == held_rs1) && (held_rs1 != REG_ZERO)) begin
            o_operand1 <= i_wb_data;
         end
         if (i_wb_en && (i_wb_addr == held_rs2) && (held_rs2 != REG_ZERO) &&
             !held_use_imm) begin
            o_operand2 <= i_wb_data;
         end
      end else if (o_valid && i_ready) begin
         o_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;
   import operand_fetch_pkg::*;

   logic           i_clk = 1'b0;
   logic           i_rst = 1'b1;
   logic           i_valid = 1'b0;
   logic           o_ready;
   t_alu_operation i_operation = ALU_OP_ADD;
   t_reg_addr      i_rs1 = '0;
   t_reg_addr      i_rs2 = '0;
   t_reg_addr      i_rd = '0;
   t_data          i_imm = '0;
   logic           i_use_imm = 1'b0;
   logic           i_flush = 1'b0;
   logic           i_wb_en = 1'b0;
   t_reg_addr      i_wb_addr = '0;
   t_data          i_wb_data = '0;
   logic           o_valid;
   logic           i_ready = 1'b1;
   t_alu_operation o_operation;
   t_data          o_operand1;
   t_data          o_operand2;
   t_reg_addr      o_rd;

   typedef struct {
      t_alu_operation op;
      t_data          a;
      t_data          b;
      t_reg_addr      rd;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   always #5 i_clk = ~i_clk;

   operand_fetch dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_operation (i_operation),
      .i_rs1       (i_rs1),
      .i_rs2       (i_rs2),
      .i_rd        (i_rd),
      .i_imm       (i_imm),
      .i_use_imm   (i_use_imm),
      .i_flush     (i_flush),
      .i_wb_en     (i_wb_en),
      .i_wb_addr   (i_wb_addr),
      .i_wb_data   (i_wb_data),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_operation (o_operation),
      .o_operand1  (o_operand1),
      .o_operand2  (o_operand2),
      .o_rd        (o_rd)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every downstream transfer must match the oldest expectation.
   always @(negedge i_clk) begin
      if (!i_rst && o_valid && i_ready) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_output: got rd=%0d with empty scoreboard", o_rd);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("out_operation", 32'(o_operation), 32'(e.op));
            check("out_operand1", o_operand1, e.a);
            check("out_operand2", o_operand2, e.b);
            check("out_rd", 32'(o_rd), 32'(e.rd));
         end
      end
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic wb(input t_reg_addr a, input t_data d);
      i_wb_en = 1'b1; i_wb_addr = a; i_wb_data = d;
      tick();
      i_wb_en = 1'b0;
   endtask

   // Present one instruction for one edge; optionally record its expected output.
   task automatic send(input t_alu_operation op, input t_reg_addr rs1, input t_reg_addr rs2,
                       input t_reg_addr rd, input t_data imm, input logic use_imm,
                       input t_data ea, input t_data eb, input logic push);
      exp_t e;
      i_valid = 1'b1; i_operation = op; i_rs1 = rs1; i_rs2 = rs2;
      i_rd = rd; i_imm = imm; i_use_imm = use_imm;
      if (push) begin
         e.op = op; e.a = ea; e.b = eb; e.rd = rd;
         sb.push_back(e);
      end
      tick();
      i_valid = 1'b0;
   endtask

   initial begin
      // Reset state
      tick(); tick();
      check("reset_o_valid", 32'(o_valid), 32'd0);
      check("reset_o_operation", 32'(o_operation), 32'(ALU_OP_ADD));
      check("reset_o_operand1", o_operand1, 32'd0);
      check("reset_o_operand2", o_operand2, 32'd0);
      check("reset_o_rd", 32'(o_rd), 32'd0);
      check("reset_o_ready", 32'(o_ready), 32'd1);
      i_rst = 1'b0;
      tick();

      // Basic read
      wb(5'd5, 32'h0000_0010);
      wb(5'd6, 32'h0000_0003);
      send(ALU_OP_SUB, 5'd5, 5'd6, 5'd1, 32'h0, 1'b0, 32'h10, 32'h3, 1'b1);
      check("latency_o_valid", 32'(o_valid), 32'd1);
      tick();

      // x0 write ignored, immediate select
      wb(5'd0, 32'h0000_1234);
      send(ALU_OP_ADD, 5'd0, 5'd0, 5'd2, 32'hFFFF_FFFC, 1'b1, 32'h0, 32'hFFFF_FFFC, 1'b1);
      send(ALU_OP_OR, 5'd0, 5'd0, 5'd3, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);

      // Same-cycle writeback bypass, then value persists in the file
      i_wb_en = 1'b1; i_wb_addr = 5'd7; i_wb_data = 32'hDEAD_BEEF;
      send(ALU_OP_XOR, 5'd7, 5'd7, 5'd4, 32'h0, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
      i_wb_en = 1'b0;
      send(ALU_OP_AND, 5'd7, 5'd5, 5'd8, 32'h0, 1'b0, 32'hDEAD_BEEF, 32'h10, 1'b1);
      tick();

      // Stall with operand-2 refresh; new instruction held off
      i_ready = 1'b0;
      send(ALU_OP_SLT, 5'd5, 5'd9, 5'd9, 32'h0, 1'b0, 32'h10, 32'h55, 1'b1);
      i_valid = 1'b1; i_operation = ALU_OP_ADD; i_rs1 = 5'd6; i_rs2 = 5'd6;
      i_rd = 5'd10; i_use_imm = 1'b0;
      sb.push_back('{ALU_OP_ADD, 32'h3, 32'h3, 5'd10});
      i_wb_en = 1'b1; i_wb_addr = 5'd9; i_wb_data = 32'h55;
      #0;
      check("stall_o_ready", 32'(o_ready), 32'd0);
      tick();
      i_wb_en = 1'b0;
      tick();
      check("stall_held_valid", 32'(o_valid), 32'd1);
      check("stall_held_rd", 32'(o_rd), 32'd9);
      i_ready = 1'b1;
      tick();
      i_valid = 1'b0;
      tick();

      // Stall with immediate operand: rs1 refreshes, operand 2 keeps imm
      i_ready = 1'b0;
      send(ALU_OP_ADD, 5'd9, 5'd9, 5'd11, 32'h77, 1'b1, 32'hAA, 32'h77, 1'b1);
      wb(5'd9, 32'hAA);
      i_ready = 1'b1;
      tick();

      // Four back-to-back instructions
      send(ALU_OP_ADD, 5'd5, 5'd6, 5'd1, 32'h0, 1'b0, 32'h10, 32'h3, 1'b1);
      check("stream_valid_1", 32'(o_valid), 32'd1);
      send(ALU_OP_SUB, 5'd6, 5'd0, 5'd2, 32'h100, 1'b1, 32'h3, 32'h100, 1'b1);
      check("stream_valid_2", 32'(o_valid), 32'd1);
      send(ALU_OP_AND, 5'd7, 5'd9, 5'd3, 32'h0, 1'b0, 32'hDEAD_BEEF, 32'hAA, 1'b1);
      check("stream_valid_3", 32'(o_valid), 32'd1);
      send(ALU_OP_OR, 5'd0, 5'd5, 5'd4, 32'h0, 1'b0, 32'h0, 32'h10, 1'b1);
      check("stream_valid_4", 32'(o_valid), 32'd1);
      tick();

      // Flush on the third accept; concurrent writeback still lands
      send(ALU_OP_XOR, 5'd5, 5'd5, 5'd5, 32'h0, 1'b0, 32'h10, 32'h10, 1'b1);
      send(ALU_OP_SLL, 5'd6, 5'd0, 5'd6, 32'h1, 1'b1, 32'h3, 32'h1, 1'b1);
      i_flush = 1'b1;
      i_wb_en = 1'b1; i_wb_addr = 5'd10; i_wb_data = 32'h99;
      send(ALU_OP_SRL, 5'd10, 5'd0, 5'd7, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
      i_flush = 1'b0; i_wb_en = 1'b0;
      check("flush_o_valid", 32'(o_valid), 32'd0);
      send(ALU_OP_ADD, 5'd10, 5'd10, 5'd8, 32'h0, 1'b0, 32'h99, 32'h99, 1'b1);
      tick();

      // Asynchronous reset while an instruction is held
      i_ready = 1'b0;
      send(ALU_OP_SUB, 5'd5, 5'd6, 5'd12, 32'h0, 1'b0, 32'h10, 32'h3, 1'b1);
      check("pre_reset_o_valid", 32'(o_valid), 32'd1);
      #2;
      i_rst = 1'b1;
      #1;
      check("async_rst_o_valid", 32'(o_valid), 32'd0);
      check("async_rst_operand1", o_operand1, 32'd0);
      check("async_rst_operand2", o_operand2, 32'd0);
      check("async_rst_rd", 32'(o_rd), 32'd0);
      sb.delete();
      tick();
      i_rst = 1'b0;
      i_ready = 1'b1;
      send(ALU_OP_ADD, 5'd5, 5'd7, 5'd1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
      send(ALU_OP_ADD, 5'd10, 5'd9, 5'd2, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);

      // Drain with a bounded wait
      for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
      tick();
      check("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Register-read stage directly upstream of the ALU.
- Accepts a decoded instruction, reads rs1/rs2 from an internal register file (with writeback bypass), and selects the immediate or rs2 for operand 2.
- Registers operation, operands and rd into a single-entry output stage, using valid/ready handshakes on both sides.
- Owns the architectural register file; writeback arrives on a dedicated write port.

Parameters:
- XLEN, 32, data width; must match t_data.
- NUM_REGS, 32, number of architectural registers; x0 is hardwired to zero.
- REG_ADDR_W, 5, register index width; equals $clog2(NUM_REGS).

Ports:
- i_clk  input  1  clock; all state updates on the rising edge
- i_rst  input  1  reset, asynchronous, active-high
- i_valid  input  1  upstream instruction valid
- o_ready  output  1  stage can accept an instruction this cycle
- i_operation  input  t_alu_operation  ALU operation to issue
- i_rs1  input  REG_ADDR_W  source register 1 index
- i_rs2  input  REG_ADDR_W  source register 2 index
- i_rd  input  REG_ADDR_W  destination register index, passed through
- i_imm  input  XLEN  sign-extended immediate
- i_use_imm  input  1  1: operand2 = i_imm; 0: operand2 = reg[rs2]
- i_flush  input  1  kill the held instruction and any incoming instruction
- i_wb_en  input  1  register file write enable
- i_wb_addr  input  REG_ADDR_W  write index
- i_wb_data  input  XLEN  write data
- o_valid  output  1  output instruction valid
- i_ready  input  1  downstream (ALU/execute) accepts
- o_operation  output  t_alu_operation  registered operation
- o_operand1  output  XLEN  registered operand 1
- o_operand2  output  XLEN  registered operand 2
- o_rd  output  REG_ADDR_W  registered destination

Behaviour:
- Reset (asynchronous, i_rst=1):
  - o_valid=0, o_operation=ALU_OP_ADD, o_operand1=0, o_operand2=0, o_rd=0.
  - All registers cleared to 0.
  - Held rs1/rs2/use_imm cleared to 0.
  - Reset mid-transfer drops the instruction; no partial state survives.
- Register file:
  - Write at the rising edge when i_wb_en=1 and i_wb_addr!=0.
  - Writes to x0 are ignored, and x0 always reads 0.
- Read bypass: if i_wb_en=1, i_wb_addr==rsN and rsN!=0, the read value is i_wb_data (same-cycle write is visible). Otherwise the read value is reg[rsN].
- Handshake:
  - o_ready = !o_valid || i_ready, purely combinational from o_valid and i_ready.
  - Accept = i_valid && o_ready. On accept, the output registers capture:
    - i_operation and i_rd;
    - bypassed rs1 value into o_operand1;
    - i_use_imm ? i_imm : bypassed rs2 value into o_operand2;
    - rs1, rs2 and use_imm into held copies.
  - Next-state o_valid: 1 on accept; 0 if o_valid && i_ready && !accept; otherwise unchanged.
  - Latency is one cycle from accept to o_valid.
  - Throughput is one instruction per cycle when i_ready is held at 1.
- Stall (o_valid=1, i_ready=0):
  - o_operation, o_rd and o_valid are held.
  - Held-operand refresh: if i_wb_en=1 and i_wb_addr==held rs1 and held rs1!=0, o_operand1 <= i_wb_data.
  - Same rule for operand 2 using held rs2, applied only when held use_imm=0.
  - This keeps a stalled instruction from issuing stale data. No other output changes while stalled.
- Flush:
  - i_flush=1 at an edge forces o_valid<=0 and suppresses accept, even if i_valid && o_ready.
  - The register file write in the same cycle still occurs.
  - Flush has priority over accept and stall. Output data registers may hold stale values while o_valid=0.
- Simultaneous writeback and accept: the accepted instruction sees the new value (bypass), and the register file is also updated.
- Arithmetic: none; all data paths are XLEN wide with no extension beyond i_imm being pre-extended upstream.

Decomposition:
- Package definitions:
  - Already holds t_data and t_alu_operation.
  - Add t_reg_addr (logic [REG_ADDR_W-1:0]) and the constant REG_ZERO = 0.
- Sub-module register_file:
  - Two combinational read ports with write-first bypass, one synchronous write port, x0 hardwired to zero, asynchronous clear.
  - operand_fetch instantiates one register_file and contains the handshake, operand mux and refresh logic.

Test Plan:
- Reset then write x5=0x0000_0010 and x6=0x0000_0003; issue SUB rs1=5 rs2=6 use_imm=0 -> next cycle o_valid=1, o_operand1=0x10, o_operand2=0x3, o_operation=ALU_OP_SUB.
- Issue ADD rs1=0 use_imm=1 imm=0xFFFF_FFFC after attempting wb x0=0x1234 -> o_operand1=0, o_operand2=0xFFFF_FFFC.
- Same-cycle wb x7=0xDEAD_BEEF with accept of rs1=7 -> o_operand1=0xDEAD_BEEF one cycle later.
- Hold i_ready=0 with o_valid=1 (rs2=9, use_imm=0), then wb x9=0x55 -> o_operand2 becomes 0x55; o_ready=0, and a new i_valid is not accepted until i_ready=1.
- Stream 4 back-to-back instructions with i_ready=1 -> 4 consecutive o_valid cycles in order, no bubbles; assert i_flush in the cycle of the 3rd accept -> the 3rd instruction never appears and o_valid=0 the next cycle.
- Assert i_rst asynchronously (between edges) while o_valid=1 -> o_valid=0 and all registers read 0 immediately, without waiting for a clock edge.
